// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via a
// ripple-borrow trial subtraction, with a start/busy/done handshake.
//
// Handshake: start is sampled only while idle (busy=0, done=0). The accepting
// edge raises busy; busy falls on the edge that raises done, and done stays
// high for exactly one cycle. A start seen while busy or done is dropped.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             diff_unused;
  logic [WIDTH-1:0] rem_next;
  logic             accept;
  logic             zero_div;
  logic             last_iter;

  // The shifted remainder needs WIDTH+1 bits (divisor may exceed 2^(WIDTH-1)),
  // so the subtraction carries one extra borrow bit above it.
  always_comb begin
    shifted   = {rem_q, work_q[WIDTH-1]};
    {borrow, diff} = {1'b0, shifted} - {2'b00, dsr_q};
    rem_next  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    accept    = (state_q == IDLE) && start;
    zero_div  = (dsr_q == '0);
    last_iter = (state_q == RUN) && (zero_div || (cnt_q == CW'(1)));
  end

  // diff[WIDTH] is always 0 when no borrow occurs, so it never reaches rem_next.
  assign diff_unused = diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A zero divisor still passes through RUN for one edge so its done lands at
  // E1 and the done cycle is spent in FIN, where start is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_iter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q      <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= last_iter;
      if (accept) begin
        work_q <= dividend;
        dsr_q  <= divisor;
        rem_q  <= '0;
        cnt_q  <= CW'(WIDTH);
        busy   <= 1'b1;
      end else if (state_q == RUN) begin
        if (zero_div) begin
          quotient    <= '1;
          remainder   <= work_q;
          div_by_zero <= 1'b1;
          busy        <= 1'b0;
          cnt_q       <= '0;
        end else begin
          work_q <= {work_q[WIDTH-2:0], ~borrow};
          rem_q  <= rem_next;
          cnt_q  <= cnt_q - CW'(1);
          if (last_iter) begin
            quotient    <= {work_q[WIDTH-2:0], ~borrow};
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised scoreboard bench for seq_divider: the driver pushes expected
// {div_by_zero, quotient, remainder} and completion cycle; a monitor pops on done.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];

  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         held_dz = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops on every done pulse, otherwise checks the results are held.
  always @(posedge clk) begin
    logic [2*W:0] e;
    int           c;
    cyc = cyc + 1;
    #1;
    if (!rst_n) begin
      held_q = '0; held_r = '0; held_dz = 1'b0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e[2*W-1:W]));
        chk("remainder", 32'(remainder), 32'(e[W-1:0]));
        chk("div_by_zero", 32'(div_by_zero), 32'(e[2*W]));
        chk("latency_cycle", 32'(cyc), 32'(c));
        chk("busy_at_done", 32'(busy), 32'd0);
        held_q = e[2*W-1:W]; held_r = e[W-1:0]; held_dz = e[2*W];
      end
    end else begin
      chk("hold_result", 32'({div_by_zero, quotient, remainder}),
          32'({held_dz, held_q, held_r}));
    end
  end

  // Reference model straight from the arithmetic definition.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk("idle_wait_timeout", 32'd1, 32'd0);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    if (b == '0) begin
      exp_q.push_back({1'b1, {W{1'b1}}, a});
      exp_cyc_q.push_back(cyc + 1);
    end else begin
      exp_q.push_back({1'b0, W'(a / b), W'(a % b)});
      exp_cyc_q.push_back(cyc + W);
    end
    chk("busy_after_accept", 32'(busy), 32'd1);
    start = 1'b0;
    if (disturb) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        dividend = W'($urandom); divisor = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!done && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) chk("done_wait_timeout", 32'd1, 32'd0);
      start = 1'b1;
      dividend = W'($urandom); divisor = W'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_outputs", 32'({div_by_zero, quotient, remainder}), 32'd0);

    issue(8'd100, 8'd7, 1'b0); drain();
    issue(8'd255, 8'd1, 1'b0); drain();
    issue(8'd3, 8'd10, 1'b0);  drain();
    issue(8'd0, 8'd9, 1'b0);   drain();
    issue(8'd5, 8'd0, 1'b0);   drain();
    issue(8'd200, 8'd16, 1'b0); drain();
    issue(8'd255, 8'd129, 1'b0); drain();
    issue(8'd77, 8'd5, 1'b1);  drain();
    issue(8'd250, 8'd255, 1'b1); drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of 200/3: nothing may complete afterwards.
    issue(8'd200, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_outputs", 32'({div_by_zero, quotient, remainder}), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);
    issue(8'd200, 8'd3, 1'b0); drain();

    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 8'd1;
        2:       b = W'($urandom_range(128, 255));
        default: b = W'($urandom);
      endcase
      issue(a, b, 1'b0);
    end
    drain();
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
